writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_pkg.sv | 23 ++
 rtl/mw_pipe_reg.sv | 46 ++++
 rtl/writeback_stage.sv | 82 ++++++++
 tb/tb_writeback_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: M/W bus layout, bus width and
// the halt FSM state encoding.
package writeback_stage_pkg;

  localparam int W_BUS_WIDTH = 39;

  localparam int ALU_MSB        = 38;
  localparam int ALU_LSB        = 23;
  localparam int MEM_MSB        = 22;
  localparam int MEM_LSB        = 7;
  localparam int WR_REG_MSB     = 6;
  localparam int WR_REG_LSB     = 3;
  localparam int HALT_BIT       = 2;
  localparam int REG_WRITE_BIT  = 1;
  localparam int MEM_TO_REG_BIT = 0;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } halt_state_e;

endpackage

// File: rtl/mw_pipe_reg.sv
// Pipeline register with async reset, stall (hold) and flush (bubble).
// Flush outranks stall; a flushed entry is all-zero with valid cleared.
module mw_pipe_reg #(
  parameter int WIDTH = 39
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             valid_in,
  output logic [WIDTH-1:0] q,
  output logic             valid_q
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    data_d = data_q;
    vld_d  = vld_q;
    if (flush) begin
      data_d = '0;
      vld_d  = 1'b0;
    end else if (!stall) begin
      data_d = d;
      vld_d  = valid_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q       = data_q;
  assign valid_q = vld_q;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: M/W register, result select, register-write gating, halt FSM.
// Define WB_PERF_CNT_EN to add the retired-instruction counter and retired_cnt port.
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W_BUS_WIDTH-1:0] W_in,
  input  logic                   valid_M,
  input  logic                   stall_W,
  input  logic                   flush_W,
  output logic [15:0]            wr_data_W,
  output logic [3:0]             wr_reg_W,
  output logic                   RegWrite_W,
  output logic                   halt_pend,
  output logic                   hlt
`ifdef WB_PERF_CNT_EN
  ,
  output logic [15:0]            retired_cnt
`endif
);

  halt_state_e            state_q, state_d;
  logic [W_BUS_WIDTH-1:0] w_q;
  logic                   valid_w;
  logic                   halted;

  assign halted = (state_q == HALTED);

  // Once halted the register is frozen regardless of stall/flush requests.
  mw_pipe_reg #(
    .WIDTH (W_BUS_WIDTH)
  ) u_mw_reg (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall_W | halted),
    .flush    (flush_W & ~halted),
    .d        (W_in),
    .valid_in (valid_M),
    .q        (w_q),
    .valid_q  (valid_w)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (valid_w && w_q[HALT_BIT] && !stall_W) state_d = HALT_PEND;
      HALT_PEND: state_d = HALTED;
      HALTED:    state_d = HALTED;
      default:   state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign wr_data_W  = w_q[MEM_TO_REG_BIT] ? w_q[MEM_MSB:MEM_LSB] : w_q[ALU_MSB:ALU_LSB];
  assign wr_reg_W   = w_q[WR_REG_MSB:WR_REG_LSB];
  // R0 is hard-wired zero, so writes to it are suppressed here.
  assign RegWrite_W = w_q[REG_WRITE_BIT] & valid_w & (wr_reg_W != 4'd0) & ~halted;
  assign halt_pend  = (state_q != RUN);
  assign hlt        = halted;

`ifdef WB_PERF_CNT_EN
  logic [15:0] retired_cnt_q, retired_cnt_d;

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (valid_w && !stall_W && !halted) retired_cnt_d = retired_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_cnt_q <= 16'd0;
    else     retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboarded bench for writeback_stage: driver pushes model predictions,
// monitor pops and compares after each rising edge.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [38:0] W_in;
  logic        valid_M, stall_W, flush_W;
  logic [15:0] wr_data_W;
  logic [3:0]  wr_reg_W;
  logic        RegWrite_W, halt_pend, hlt;
`ifdef WB_PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk        (clk),
    .rst        (rst),
    .W_in       (W_in),
    .valid_M    (valid_M),
    .stall_W    (stall_W),
    .flush_W    (flush_W),
    .wr_data_W  (wr_data_W),
    .wr_reg_W   (wr_reg_W),
    .RegWrite_W (RegWrite_W),
    .halt_pend  (halt_pend),
    .hlt        (hlt)
`ifdef WB_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  typedef struct {
    logic [15:0] data;
    bit          known;
    logic [3:0]  wr;
    logic        rw;
    logic        hp;
    logic        hl;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the instruction sitting in writeback plus halt/count bookkeeping.
  bit          m_valid, m_halt, m_rw, m_m2r, m_known, m_pend, m_halted;
  logic [15:0] m_alu, m_mem, m_cnt;
  logic [3:0]  m_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_halt = 0; m_rw = 0; m_m2r = 0; m_known = 1;
    m_pend = 0; m_halted = 0;
    m_alu = '0; m_mem = '0; m_cnt = '0; m_wr = '0;
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.data  = m_m2r ? m_mem : m_alu;
    e.known = m_known;
    e.wr    = m_wr;
    e.rw    = m_rw && m_valid && (m_wr != 4'd0) && !m_halted;
    e.hp    = m_pend || m_halted;
    e.hl    = m_halted;
    e.cnt   = m_cnt;
    return e;
  endfunction

  task automatic model_edge(input logic [15:0] alu, mem, input logic [3:0] wr,
                            input bit h, rw, m2r, vm, st, fl);
    if (m_halted) return;
    if (m_valid && !st) m_cnt = m_cnt + 16'd1;
    if (m_pend) m_halted = 1;
    else if (m_valid && m_halt && !st) m_pend = 1;
    if (fl) begin
      m_valid = 0; m_halt = 0; m_rw = 0; m_m2r = 0; m_known = 0;
    end else if (!st) begin
      m_valid = vm; m_halt = h; m_rw = rw; m_m2r = m2r;
      m_alu = alu; m_mem = mem; m_wr = wr; m_known = 1;
    end
  endtask

  // Called aligned to a falling edge; returns at the next falling edge.
  task automatic cycle(input logic [15:0] alu, mem, input logic [3:0] wr,
                       input bit h, rw, m2r, vm, st, fl);
    W_in    = {alu, mem, wr, h, rw, m2r};
    valid_M = vm;
    stall_W = st;
    flush_W = fl;
    model_edge(alu, mem, wr, h, rw, m2r, vm, st, fl);
    sb.push_back(model_outputs());
    @(negedge clk);
  endtask

  task automatic rand_cycle(input int halt_pct, input int stall_pct, input int flush_pct);
    cycle(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 99) < halt_pct), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 80),
          ($urandom_range(0, 99) < stall_pct), ($urandom_range(0, 99) < flush_pct));
  endtask

  // Asserts reset mid-cycle and checks outputs before any clock edge.
  task automatic apply_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, " wr_data_W"}, wr_data_W, 0);
    check({tag, " wr_reg_W"}, wr_reg_W, 0);
    check({tag, " RegWrite_W"}, RegWrite_W, 0);
    check({tag, " halt_pend"}, halt_pend, 0);
    check({tag, " hlt"}, hlt, 0);
`ifdef WB_PERF_CNT_EN
    check({tag, " retired_cnt"}, retired_cnt, 0);
`endif
    model_reset();
    @(negedge clk);
    W_in = '0; valid_M = 0; stall_W = 0; flush_W = 0;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.known) begin
          check("wr_data_W", wr_data_W, e.data);
          check("wr_reg_W", wr_reg_W, e.wr);
        end
        check("RegWrite_W", RegWrite_W, e.rw);
        check("halt_pend", halt_pend, e.hp);
        check("hlt", hlt, e.hl);
`ifdef WB_PERF_CNT_EN
        check("retired_cnt", retired_cnt, e.cnt);
`endif
      end
    end
  end

  initial begin : driver
    rst = 1'b1; W_in = '0; valid_M = 0; stall_W = 0; flush_W = 0;
    model_reset();
    @(negedge clk);
    apply_reset("reset");

    // Result select and R0 guard
    cycle(16'h1234, 16'hBEEF, 4'd5, 0, 1, 1, 1, 0, 0);
    cycle(16'h1234, 16'hBEEF, 4'd5, 0, 1, 0, 1, 0, 0);
    cycle(16'hAAAA, 16'h5555, 4'd0, 0, 1, 1, 1, 0, 0);
    cycle(16'h0F0F, 16'hF0F0, 4'd9, 0, 1, 0, 1, 0, 0);

    // Stall holds for three cycles, then flush beats stall
    repeat (3) cycle(16'($urandom), 16'($urandom), 4'd7, 0, 1, 1, 1, 1, 0);
    cycle(16'h1111, 16'h2222, 4'd3, 0, 1, 0, 1, 1, 1);
    cycle(16'h3333, 16'h4444, 4'd4, 0, 1, 0, 1, 0, 0);

    repeat (300) rand_cycle(0, 25, 10);

    // Flushed and invalid halts must not start the halt sequence
    cycle(16'h0, 16'h0, 4'd3, 1, 1, 0, 1, 0, 1);
    cycle(16'h0, 16'h0, 4'd3, 1, 1, 0, 0, 0, 0);
    repeat (3) cycle(16'h0101, 16'h0202, 4'd2, 0, 1, 0, 0, 0, 0);

    // Valid halt held by a stall, then released
    cycle(16'h00AA, 16'h00BB, 4'd6, 1, 1, 0, 1, 0, 0);
    repeat (2) cycle(16'h0C0C, 16'h0D0D, 4'd8, 0, 1, 0, 1, 1, 0);
    repeat (6) cycle(16'($urandom), 16'($urandom), 4'd10, 0, 1, 0, 1, 0, 0);
    repeat (4) rand_cycle(0, 25, 25);

    apply_reset("reset in halted");

`ifdef WB_PERF_CNT_EN
    while (m_cnt != 16'hFFFE) cycle(16'($urandom), 16'($urandom), 4'd1, 0, 1, 0, 1, 0, 0);
    repeat (2) cycle(16'h5A5A, 16'hA5A5, 4'd1, 0, 1, 0, 1, 0, 0);
    check("retired_cnt wrap", retired_cnt, 16'h0000);
    apply_reset("reset after wrap");
`endif

    repeat (400) rand_cycle(2, 20, 10);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
